// File: rtl/mon_mem_engine.sv
// UART-monitor memory engine: word writes with auto-increment, line-buffered range dump,
// and constant/incrementing fill of the data RAM.
module mon_mem_engine #(
  parameter int LINE_W  = 128,
  parameter int ADR_W   = 32,
  parameter int FILL_AW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         cmd_data,
  input  logic                wadr_set,
  input  logic                wdata_en,
  input  logic                rd_start_set,
  input  logic                rd_end_set,
  input  logic                rd_stop,
  input  logic                fill_start,
  input  logic                fill_inc,
  output logic [ADR_W-1:0]    ram_wadr,
  output logic [LINE_W-1:0]   ram_wdata,
  output logic [LINE_W/8-1:0] ram_wmask,
  output logic                ram_wen,
  output logic [ADR_W-1:0]    ram_radr,
  output logic                ram_rreq,
  input  logic [LINE_W-1:0]   ram_rdata,
  input  logic                ram_rvalid,
  output logic                snd_start,
  output logic [63:0]         snd_data,
  input  logic                snd_done,
  output logic                busy,
  output logic                fill_running
);
  localparam int LANES = LINE_W / 32;
  localparam int LB    = $clog2(LANES);
  localparam int WB    = ADR_W - 2;
  localparam int MB    = LINE_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_RREQ, S_RWAIT, S_SEND, S_SWAIT} state_t;
  state_t state_q, state_d;

  logic [WB-1:0]      wptr, rptr, end_w, rptr_nx, fill_adr;
  logic [LINE_W-1:0]  linebuf;
  logic [FILL_AW-1:0] fill_cnt;
  logic [31:0]        pattern, fill_word;
  logic               fill_inc_q, wr_ok;

  function automatic logic [ADR_W-1:0] line_adr(input logic [WB-1:0] w);
    line_adr = {w[WB-1:LB], {(LB+2){1'b0}}};
  endfunction

  // Active-low byte mask: only the four bytes of the addressed lane are written.
  function automatic logic [MB-1:0] lane_mask(input logic [LB-1:0] lane);
    lane_mask = ~({{(MB-4){1'b0}}, 4'hF} << {lane, 2'b00});
  endfunction

  assign busy      = (state_q != S_IDLE) | fill_running;
  assign wr_ok     = wdata_en & ~wadr_set & ~fill_running & ~rst;
  assign fill_adr  = WB'(fill_cnt);
  assign fill_word = fill_inc_q ? pattern + 32'(fill_cnt) : pattern;
  assign rptr_nx   = rptr + WB'(2);

  always_comb begin
    ram_wen   = 1'b0;
    ram_wadr  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (fill_running && !rst) begin
      ram_wen   = 1'b1;
      ram_wadr  = line_adr(fill_adr);
      ram_wdata = {LANES{fill_word}};
      ram_wmask = lane_mask(fill_adr[LB-1:0]);
    end else if (wr_ok) begin
      ram_wen   = 1'b1;
      ram_wadr  = line_adr(wptr);
      ram_wdata = {LANES{cmd_data}};
      ram_wmask = lane_mask(wptr[LB-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wptr         <= '0;
      rptr         <= '0;
      end_w        <= '0;
      linebuf      <= '0;
      fill_running <= 1'b0;
      fill_cnt     <= '0;
      pattern      <= '0;
      fill_inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (wadr_set)   wptr <= cmd_data[ADR_W-1:2];
      else if (wr_ok) wptr <= wptr + 1'b1;

      if (fill_running) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (&fill_cnt) fill_running <= 1'b0;
      end else if (fill_start && !busy) begin
        fill_running <= 1'b1;
        fill_cnt     <= '0;
        pattern      <= cmd_data;
        fill_inc_q   <= fill_inc;
      end

      // Range registers only move while no dump is in flight.
      if (state_q == S_IDLE) begin
        if (rd_start_set) rptr <= {cmd_data[ADR_W-1:3], 1'b0};
        if (rd_end_set && !fill_running) end_w <= cmd_data[ADR_W-1:2];
      end
      if (state_q == S_RWAIT && ram_rvalid && !rd_stop) linebuf <= ram_rdata;
      if (state_q == S_SWAIT && snd_done && !rd_stop)   rptr    <= rptr_nx;
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_rreq  = 1'b0;
    ram_radr  = '0;
    snd_start = 1'b0;
    snd_data  = '0;
    case (state_q)
      S_IDLE:  if (rd_end_set && !fill_running) state_d = S_RREQ;
      S_RREQ: begin
        ram_rreq = 1'b1;
        ram_radr = line_adr(rptr);
        state_d  = S_RWAIT;
      end
      S_RWAIT: if (ram_rvalid) state_d = S_SEND;
      S_SEND: begin
        snd_start = 1'b1;
        snd_data  = linebuf[{rptr[LB-1:0], 5'b0} +: 64];
        state_d   = S_SWAIT;
      end
      S_SWAIT: begin
        // A pointer that wraps to zero has run off the top of memory and ends the dump.
        if (snd_done) begin
          if (rptr_nx == '0 || rptr_nx > end_w) state_d = S_IDLE;
          else if (rptr_nx[LB-1:0] == '0)      state_d = S_RREQ;
          else                                  state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_stop && state_q != S_IDLE) state_d = S_IDLE;
  end
endmodule
